// File: rtl/mem_stage_ctrl.sv
// Memory-stage access sequencer: drives one EX/M load or store onto the shared
// data-memory port over req/gnt/rvalid, stalls the pipeline until done, latches load data.
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Mem_Read_M,
  input  logic              Mem_Write_M,
  input  logic [DATA_W-1:0] ALU_result_M,
  input  logic [DATA_W-1:0] Write_Data_M,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              stall_M,
  output logic [DATA_W-1:0] Read_Data_M,
  output logic              mem_err,
  output logic [1:0]        dbg_state_o
);

  // Handshake: bus_req stays high with fields held until the cycle bus_gnt is
  // sampled high; load data is taken only in the cycle bus_rvalid is high in WAIT_R.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e              state_q;
  logic                bus_req_q;
  logic                bus_we_q;
  logic [DATA_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                mem_err_q;
  logic [TO_W-1:0]     cnt_q;

  logic                op;
  logic                misaligned;
  logic                timeout_hit;

  assign op          = Mem_Read_M | Mem_Write_M;
  assign misaligned  = (ALU_result_M[1:0] != 2'b00);
  // The cycle that would take the counter to TIMEOUT is the last one allowed.
  assign timeout_hit = (cnt_q >= TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      mem_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op) begin
            if (misaligned) begin
              mem_err_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              bus_addr_q  <= {ALU_result_M[DATA_W-1:2], 2'b00};
              bus_wdata_q <= Write_Data_M;
              bus_we_q    <= Mem_Write_M;
              bus_req_q   <= 1'b1;
              cnt_q       <= '0;
              state_q     <= S_REQ;
              if (Mem_Read_M && Mem_Write_M) mem_err_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus_gnt) begin
            bus_req_q <= 1'b0;
            state_q   <= bus_we_q ? S_DONE : S_WAIT_R;
          end else if (timeout_hit) begin
            bus_req_q <= 1'b0;
            mem_err_q <= 1'b1;
            if (!bus_we_q) rdata_q <= DATA_W'(32'hDEAD_BEEF);
            state_q   <= S_DONE;
          end
        end
        S_WAIT_R: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus_rvalid) begin
            rdata_q <= bus_rdata;
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            mem_err_q <= 1'b1;
            rdata_q   <= DATA_W'(32'hDEAD_BEEF);
            state_q   <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stall_M     = rst_n & op & (state_q != S_DONE);
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign Read_Data_M = rdata_q;
  assign mem_err     = mem_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed accesses push expected bus and
// completion records; a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_stage_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         Mem_Read_M, Mem_Write_M;
  logic [W-1:0] ALU_result_M, Write_Data_M;
  logic         bus_gnt, bus_rvalid;
  logic [W-1:0] bus_rdata;
  logic         bus_req, bus_we;
  logic [W-1:0] bus_addr, bus_wdata;
  logic         stall_M;
  logic [W-1:0] Read_Data_M;
  logic         mem_err;
  logic [1:0]   dbg_state_o;

  mem_stage_ctrl #(.DATA_W(W), .TIMEOUT(8), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .Mem_Read_M(Mem_Read_M), .Mem_Write_M(Mem_Write_M),
    .ALU_result_M(ALU_result_M), .Write_Data_M(Write_Data_M),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .stall_M(stall_M), .Read_Data_M(Read_Data_M), .mem_err(mem_err),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // {we, addr, wdata} per bus request; {stall, req_cycles, err, rdata} per completion
  logic [2*W:0]  exp_bus_q[$];
  logic [W+16:0] exp_done_q[$];

  task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n        = 1'b0;
    Mem_Read_M   = 1'b1;
    Mem_Write_M  = 1'b0;
    ALU_result_M = 32'h104;
    Write_Data_M = '0;
    bus_gnt      = 1'b0;
    bus_rvalid   = 1'b0;
    bus_rdata    = '0;
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_read_data", Read_Data_M, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_stall", stall_M, 0);
    check("rst_state", dbg_state_o, 0);
    @(posedge clk); #1;
    Mem_Read_M = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    Mem_Read_M  = 1'b0;
    Mem_Write_M = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Driver: called just after a rising edge; cycle 0 is the IDLE cycle, cycle 1 the first REQ.
  task automatic access(input logic rd, input logic wr, input logic [W-1:0] addr,
                        input logic [W-1:0] wdata, input int gnt_cyc, input int rv_cyc,
                        input logic [W-1:0] rdata, input int exp_stall, input int exp_req,
                        input logic exp_err, input logic [W-1:0] exp_rd);
    logic done;
    if (exp_req > 0) exp_bus_q.push_back({wr, addr & 32'hFFFF_FFFC, wdata});
    exp_done_q.push_back({8'(exp_stall), 8'(exp_req), exp_err, exp_rd});
    Mem_Read_M   = rd;
    Mem_Write_M  = wr;
    ALU_result_M = addr;
    Write_Data_M = wdata;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      bus_gnt    = (c == gnt_cyc);
      bus_rvalid = (c == rv_cyc);
      bus_rdata  = (c == rv_cyc) ? rdata : '0;
      @(negedge clk);
      if (!stall_M) done = 1'b1;
      @(posedge clk); #1;
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL access_timeout: addr %0h never completed within 64 cycles", addr);
    end
  endtask

  // Scoreboard monitor
  int            stall_cnt = 0;
  int            req_cnt   = 0;
  logic          req_prev  = 1'b0;
  logic [2*W:0]  be;
  logic [W+16:0] de;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt = 0;
      req_cnt   = 0;
      req_prev  = 1'b0;
    end else begin
      if (bus_req && !req_prev) begin
        if (exp_bus_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL bus_unexpected: got req addr %0h expected no request", bus_addr);
        end else begin
          be = exp_bus_q.pop_front();
          check("bus_we", bus_we, be[2*W]);
          check("bus_addr", bus_addr, be[2*W-1:W]);
          check("bus_wdata", bus_wdata, be[W-1:0]);
        end
      end
      req_prev = bus_req;
      if ((Mem_Read_M || Mem_Write_M) && !stall_M) begin
        if (exp_done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected: got completion expected none");
        end else begin
          de = exp_done_q.pop_front();
          check("stall_cycles", stall_cnt, de[W+16:W+9]);
          check("req_cycles", req_cnt, de[W+8:W+1]);
          check("mem_err", mem_err, de[W]);
          check("read_data", Read_Data_M, de[W-1:0]);
          check("done_state", dbg_state_o, 3);
        end
        stall_cnt = 0;
        req_cnt   = 0;
      end else begin
        if (stall_M) stall_cnt++;
        if (bus_req) req_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dut();
    idle(1);
    // store, immediate grant
    access(1'b0, 1'b1, 32'h100, 32'hA5A5_0001, 1, -1, '0, 2, 1, 1'b0, 32'h0);
    idle(2);
    // load, grant in 4th REQ cycle, rvalid two cycles later
    access(1'b1, 1'b0, 32'h204, '0, 4, 6, 32'h1234_5678, 7, 4, 1'b0, 32'h1234_5678);
    idle(1);
    // two back-to-back loads
    access(1'b1, 1'b0, 32'h300, '0, 1, 2, 32'hCAFE_0001, 3, 1, 1'b0, 32'hCAFE_0001);
    access(1'b1, 1'b0, 32'h304, '0, 2, 4, 32'hCAFE_0002, 5, 2, 1'b0, 32'hCAFE_0002);
    idle(1);
    // grant in the last allowed REQ cycle, data on first WAIT_R cycle: completion wins
    access(1'b1, 1'b0, 32'h400, '0, 8, 9, 32'h5555_AAAA, 10, 8, 1'b0, 32'h5555_AAAA);
    idle(1);
    // no grant: abort after 8 REQ cycles
    access(1'b1, 1'b0, 32'h404, '0, -1, -1, '0, 9, 8, 1'b1, 32'hDEAD_BEEF);
    idle(2);

    reset_dut();
    idle(1);
    // misaligned store: no request, one stall cycle, sticky error
    access(1'b0, 1'b1, 32'h102, 32'h77, -1, -1, '0, 1, 0, 1'b1, 32'h0);
    idle(3);
    @(negedge clk);
    check("mem_err_sticky", mem_err, 1);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'h108, 32'h99, 1, -1, '0, 2, 1, 1'b1, 32'h0);
    idle(1);

    reset_dut();
    idle(1);
    // reset in the middle of WAIT_R, then a late rvalid
    exp_bus_q.push_back({1'b0, 32'h500, 32'h0});
    Mem_Read_M   = 1'b1;
    ALU_result_M = 32'h500;
    Write_Data_M = '0;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_r_state", dbg_state_o, 2);
    check("wait_r_stall", stall_M, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_bus_req", bus_req, 0);
    check("midrst_stall", stall_M, 0);
    check("midrst_state", dbg_state_o, 0);
    Mem_Read_M = 1'b0;
    @(posedge clk); #1;
    rst_n      = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    @(negedge clk);
    check("late_rvalid_data", Read_Data_M, 0);
    check("late_rvalid_state", dbg_state_o, 0);
    check("late_rvalid_err", mem_err, 0);
    @(posedge clk); #1;

    idle(3);
    check("bus_q_empty", exp_bus_q.size(), 0);
    check("done_q_empty", exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
